abuf_scheduler: RTL and testbench

//  Audio sample buffer controller between the APB control unit and the DSP/I2S path.
//  - Accepts 24-bit samples from APB writes (left/right alternating) into a ping-pong buffer.
//  - Sequences playback: on each audio request it issues one stereo pair and a tick.
//  - Raises an interrupt each time one half of the buffer has been consumed.

---
 rtl/audioport_pkg.sv | 13 +
 rtl/abuf_ram.sv | 37 +++
 rtl/abuf_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_abuf_scheduler.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/audioport_pkg.sv
// Shared types and defaults for the audio sample buffer controller.
// Buffer geometry and the playback state encoding live here.
package audioport_pkg;

  localparam int AUDIO_BUFFER_SIZE = 16;
  localparam int AUDIO_SAMPLE_BITS = 24;

  typedef enum logic {
    STOPPED = 1'b0,
    PLAYING = 1'b1
  } abuf_state_t;

endpackage : audioport_pkg

// File: rtl/abuf_ram.sv
// Sample storage: register array with one synchronous write port and two
// combinational read ports (left sample at raddr0, right sample at raddr1).
module abuf_ram
  import audioport_pkg::*;
#(
  parameter int DEPTH = 2 * AUDIO_BUFFER_SIZE,
  parameter int W     = AUDIO_SAMPLE_BITS,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr0_i,
  input  logic [AW-1:0] raddr1_i,
  output logic [W-1:0]  rdata0_o,
  output logic [W-1:0]  rdata1_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Sample array write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule : abuf_ram

// File: rtl/abuf_scheduler.sv
// Ping-pong audio buffer controller: APB sample writes in, one stereo pair
// per I2S request out, with half-buffer interrupt and sticky error flags.
module abuf_scheduler
  import audioport_pkg::*;
#(
  parameter int ABUF_PAIRS  = AUDIO_BUFFER_SIZE,
  parameter int SAMPLE_BITS = AUDIO_SAMPLE_BITS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_in,
  input  logic                         stop_in,
  input  logic                         clr_in,
  input  logic                         wr_in,
  input  logic [SAMPLE_BITS-1:0]       wdata_in,
  input  logic                         req_in,
  input  logic                         irq_ack_in,
  output logic [1:0][SAMPLE_BITS-1:0]  abuf_out,
  output logic                         tick_out,
  output logic                         play_out,
  output logic                         irq_out,
  output logic [$clog2(ABUF_PAIRS):0]  level_out,
  output logic                         full_out,
  output logic                         empty_out,
  output logic                         uflow_out,
  output logic                         oflow_out
);

  localparam int DEPTH = 2 * ABUF_PAIRS;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam logic [AW-2:0] HALF_LAST = (AW-1)'(ABUF_PAIRS / 2 - 1);
  localparam logic [AW-2:0] FULL_LAST = (AW-1)'(ABUF_PAIRS - 1);

  abuf_state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0][SAMPLE_BITS-1:0] abuf_q, abuf_d;
  logic tick_q, tick_d;
  logic play_q, play_d;
  logic irq_q, irq_d;
  logic uflow_q, uflow_d;
  logic oflow_q, oflow_d;

  logic full_s, empty_s, rd_req_s, rd_ok_s, wr_ok_s, wr_drop_s, irq_hit_s;
  logic [AW-1:0] rd_ptr1_s;
  logic [AW-2:0] rd_pair_s;
  logic [SAMPLE_BITS-1:0] left_s, right_s;

  abuf_ram #(
    .DEPTH (DEPTH),
    .W     (SAMPLE_BITS),
    .AW    (AW)
  ) u_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (wr_ok_s),
    .waddr_i  (wr_ptr_q),
    .wdata_i  (wdata_in),
    .raddr0_i (rd_ptr_q),
    .raddr1_i (rd_ptr1_s),
    .rdata0_o (left_s),
    .rdata1_o (right_s)
  );

  // Playback state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STOPPED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: stop dominates a simultaneous start
  always_comb begin
    state_d = state_q;
    case (state_q)
      STOPPED: begin
        if (start_in && !stop_in) state_d = PLAYING;
        else                      state_d = STOPPED;
      end
      PLAYING: begin
        if (stop_in) state_d = STOPPED;
        else         state_d = PLAYING;
      end
      default: state_d = STOPPED;
    endcase
  end

  // FSM output: play flag tracks the state being entered
  always_comb begin
    play_d = 1'b0;
    case (state_d)
      PLAYING: play_d = 1'b1;
      STOPPED: play_d = 1'b0;
      default: play_d = 1'b0;
    endcase
  end

  assign full_s    = (count_q == CW'(DEPTH));
  assign empty_s   = (count_q[CW-1:1] == '0);
  assign rd_ptr1_s = rd_ptr_q + AW'(1);
  assign rd_pair_s = rd_ptr_q[AW-1:1];
  // clr_in takes priority over both data paths
  assign rd_req_s  = req_in && (state_q == PLAYING) && !clr_in;
  assign rd_ok_s   = rd_req_s && !empty_s;
  assign wr_ok_s   = wr_in && !full_s && !clr_in;
  assign wr_drop_s = wr_in && full_s && !clr_in;
  assign irq_hit_s = rd_ok_s && ((rd_pair_s == HALF_LAST) || (rd_pair_s == FULL_LAST));

  // Pointer, count, output pair and flag next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    abuf_d   = abuf_q;
    tick_d   = 1'b0;
    irq_d    = irq_q;
    uflow_d  = uflow_q;
    oflow_d  = oflow_q;
    if (clr_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      abuf_d   = '0;
      irq_d    = 1'b0;
      uflow_d  = 1'b0;
      oflow_d  = 1'b0;
    end else begin
      if (wr_ok_s) wr_ptr_d = wr_ptr_q + AW'(1);
      else         wr_ptr_d = wr_ptr_q;
      if (wr_drop_s) oflow_d = 1'b1;
      else           oflow_d = oflow_q;
      count_d = count_q + (wr_ok_s ? CW'(1) : CW'(0)) - (rd_ok_s ? CW'(2) : CW'(0));
      tick_d  = rd_req_s;
      if (rd_ok_s) begin
        rd_ptr_d = rd_ptr_q + AW'(2);
        abuf_d   = {right_s, left_s};
      end else if (rd_req_s) begin
        abuf_d   = '0;
        uflow_d  = 1'b1;
      end else begin
        abuf_d   = abuf_q;
      end
      if (irq_hit_s)       irq_d = 1'b1;
      else if (irq_ack_in) irq_d = 1'b0;
      else                 irq_d = irq_q;
    end
  end

  // Datapath and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      abuf_q   <= '0;
      tick_q   <= 1'b0;
      play_q   <= 1'b0;
      irq_q    <= 1'b0;
      uflow_q  <= 1'b0;
      oflow_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      abuf_q   <= abuf_d;
      tick_q   <= tick_d;
      play_q   <= play_d;
      irq_q    <= irq_d;
      uflow_q  <= uflow_d;
      oflow_q  <= oflow_d;
    end
  end

  assign abuf_out  = abuf_q;
  assign tick_out  = tick_q;
  assign play_out  = play_q;
  assign irq_out   = irq_q;
  assign level_out = count_q[CW-1:1];
  assign full_out  = full_s;
  assign empty_out = empty_s;
  assign uflow_out = uflow_q;
  assign oflow_out = oflow_q;

endmodule : abuf_scheduler

// File: tb/tb_abuf_scheduler.sv
// Scoreboard bench for abuf_scheduler: directed stimulus pushes expected
// stereo pairs, a negedge monitor checks every tick against the queue.
module tb_abuf_scheduler;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_in = 1'b0, stop_in = 1'b0, clr_in = 1'b0;
  logic              wr_in = 1'b0, req_in = 1'b0, irq_ack_in = 1'b0;
  logic [23:0]       wdata_in = 24'h0;
  logic [1:0][23:0]  abuf_out;
  logic              tick_out, play_out, irq_out, full_out, empty_out, uflow_out, oflow_out;
  logic [4:0]        level_out;

  int vectors = 0;
  int miscompares = 0;
  logic [47:0] sb_q[$];

  abuf_scheduler #(.ABUF_PAIRS(16), .SAMPLE_BITS(24)) dut (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .stop_in(stop_in), .clr_in(clr_in),
    .wr_in(wr_in), .wdata_in(wdata_in), .req_in(req_in), .irq_ack_in(irq_ack_in),
    .abuf_out(abuf_out), .tick_out(tick_out), .play_out(play_out), .irq_out(irq_out),
    .level_out(level_out), .full_out(full_out), .empty_out(empty_out),
    .uflow_out(uflow_out), .oflow_out(oflow_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every tick must match the oldest outstanding expected pair
  always @(negedge clk) begin
    if (tick_out === 1'b1) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL tick: unexpected tick with abuf_out=%h, expected no tick", abuf_out);
      end else begin
        logic [47:0] exp;
        exp = sb_q.pop_front();
        if (abuf_out !== exp) begin
          miscompares++;
          $display("FAIL pair: got %h, expected %h", abuf_out, exp);
        end
      end
    end
  end

  task automatic drive(input logic st, input logic sp, input logic cl, input logic w,
                       input logic r, input logic a, input logic [23:0] d);
    @(negedge clk);
    start_in = st; stop_in = sp; clr_in = cl; wr_in = w; req_in = r; irq_ack_in = a; wdata_in = d;
    @(negedge clk);
    start_in = 1'b0; stop_in = 1'b0; clr_in = 1'b0; wr_in = 1'b0; req_in = 1'b0; irq_ack_in = 1'b0;
  endtask

  task automatic wr(input logic [23:0] d);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, d);
  endtask

  task automatic req_exp(input logic [47:0] pair);
    sb_q.push_back(pair);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
  endtask

  task automatic req_none();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_abuf"},  abuf_out, 48'h0);
    chk({tag, "_flags"}, {43'h0, tick_out, play_out, irq_out, uflow_out, oflow_out}, 48'h0);
    chk({tag, "_level"}, {43'h0, level_out}, 48'h0);
    chk({tag, "_empty_full"}, {46'h0, empty_out, full_out}, 48'h2);
  endtask

  initial begin
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill buffer with 0x000001..0x000020
    for (int i = 1; i <= 32; i++) wr(24'(i));
    chk("fill_level", {43'h0, level_out}, 48'd16);
    chk("fill_full", {47'h0, full_out}, 48'h1);
    wr(24'hABCDEF);
    chk("ovf_flag", {47'h0, oflow_out}, 48'h1);
    chk("ovf_level", {43'h0, level_out}, 48'd16);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    chk("start_play", {47'h0, play_out}, 48'h1);

    for (int k = 0; k < 4; k++) req_exp({24'(2*k+2), 24'(2*k+1)});
    chk("after4_level", {43'h0, level_out}, 48'd12);
    chk("after4_irq", {47'h0, irq_out}, 48'h0);

    for (int k = 4; k < 7; k++) req_exp({24'(2*k+2), 24'(2*k+1)});
    chk("after7_irq", {47'h0, irq_out}, 48'h0);
    req_exp({24'd16, 24'd15});
    chk("after8_irq", {47'h0, irq_out}, 48'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
    chk("ack_irq", {47'h0, irq_out}, 48'h0);
    for (int k = 8; k < 16; k++) req_exp({24'(2*k+2), 24'(2*k+1)});
    chk("after16_irq", {47'h0, irq_out}, 48'h1);
    chk("after16_empty", {47'h0, empty_out}, 48'h1);
    chk("after16_level", {43'h0, level_out}, 48'd0);

    // Underflow request returns a zero pair but still ticks
    req_exp(48'h0);
    chk("uflow_flag", {47'h0, uflow_out}, 48'h1);

    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    chk("start_stop_play", {47'h0, play_out}, 48'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);

    wr(24'h000100); wr(24'h000200); wr(24'h000300);
    chk("lone_left_level", {43'h0, level_out}, 48'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h0);
    chk("clr_level", {43'h0, level_out}, 48'd0);
    chk("clr_flags", {45'h0, irq_out, uflow_out, oflow_out}, 48'h0);
    chk("clr_play", {47'h0, play_out}, 48'h1);

    // Simultaneous write and read: net count -1
    wr(24'h000011); wr(24'h000022);
    sb_q.push_back({24'h000022, 24'h000011});
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000033);
    chk("wr_rd_level", {43'h0, level_out}, 48'd0);
    chk("wr_rd_empty", {47'h0, empty_out}, 48'h1);
    wr(24'h000044);
    chk("wr_rd_level2", {43'h0, level_out}, 48'd1);
    req_exp({24'h000044, 24'h000033});
    chk("wr_rd_level3", {43'h0, level_out}, 48'd0);

    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    wr(24'h000055); wr(24'h000066);
    req_none();
    chk("stopped_req_level", {43'h0, level_out}, 48'd1);
    chk("stopped_abuf_hold", abuf_out, {24'h000044, 24'h000033});

    // Build an irq while playing, then reset asynchronously
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    for (int i = 0; i < 16; i++) wr(24'h000500 + 24'(i));
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    for (int k = 0; k < 8; k++) req_exp({24'h000500 + 24'(2*k+1), 24'h000500 + 24'(2*k)});
    chk("pre_rst_irq", {46'h0, irq_out, play_out}, 48'h3);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    req_none();
    chk("post_rst_play", {47'h0, play_out}, 48'h0);
    chk("post_rst_level", {43'h0, level_out}, 48'd0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 48'(sb_q.size()), 48'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_abuf_scheduler
